// File: rtl/bsg_sdr_link_bringup_sequencer.sv
// bsg_sdr_link_bringup_sequencer
//   Per-subpod controller that brings the SDR fwd/rev links up in a fixed
//   order: disable, IO reset, core-side link reset, core reset release, then
//   wait for every link to report ready. On a ready timeout the sequence is
//   retried from DISABLE; after max_retries_p failed retries it parks in a
//   sticky ERROR state until start_i or abort_i.
// Ports
//   clk_i              core clock (only clock)
//   reset_n_i          synchronous active-low reset
//   start_i            begin/restart, honoured in IDLE, DONE and ERROR
//   abort_i            return to IDLE on the next edge from any state
//   link_ready_i       per-link up indication, already in the core domain
//   link_disable_o     disable to all link pads/clocks
//   link_io_reset_o    IO-side link reset
//   link_core_reset_o  core-side link reset
//   core_reset_o       subpod core reset
//   done_o / error_o   bring-up finished / failed
//   retries_o          retries used in the current run
//   state_o            FSM state encoding
module bsg_sdr_link_bringup_sequencer #(
  parameter int num_links_p      = 2,
  parameter int hold_cycles_p    = 16,
  parameter int settle_cycles_p  = 32,
  parameter int timeout_cycles_p = 1024,
  parameter int max_retries_p    = 3,
  localparam int RetW = (max_retries_p > 0) ? $clog2(max_retries_p + 1) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [num_links_p-1:0] link_ready_i,
  output logic                   link_disable_o,
  output logic                   link_io_reset_o,
  output logic                   link_core_reset_o,
  output logic                   core_reset_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [RetW-1:0]        retries_o,
  output logic [2:0]             state_o
);

  localparam int CntMax0 = (hold_cycles_p > settle_cycles_p) ? hold_cycles_p : settle_cycles_p;
  localparam int CntMax  = (CntMax0 > timeout_cycles_p) ? CntMax0 : timeout_cycles_p;
  localparam int CntW    = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] HoldLast   = CntW'(hold_cycles_p - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(settle_cycles_p - 1);
  localparam logic [CntW-1:0] ToLast     = CntW'(timeout_cycles_p - 1);
  localparam logic [CntW-1:0] CntSat     = CntW'(CntMax);
  localparam logic [RetW-1:0] RetMax     = RetW'(max_retries_p);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DISABLE    = 3'd1,
    IO_RESET   = 3'd2,
    CORE_RESET = 3'd3,
    ENABLE     = 3'd4,
    WAIT_READY = 3'd5,
    DONE       = 3'd6,
    ERROR      = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [RetW-1:0] retries_q, retries_d;
  logic [5:0]      outs_q;   // {dis, io, core_lnk, core_rst, done, err}

  // Output pattern for a state; registered from the next state so the
  // outputs change on the same edge as state_o.
  function automatic logic [5:0] state_outs(state_e s);
    case (s)
      IDLE, DISABLE:      state_outs = 6'b1111_00;
      IO_RESET:           state_outs = 6'b0111_00;
      CORE_RESET:         state_outs = 6'b0011_00;
      ENABLE, WAIT_READY: state_outs = 6'b0000_00;
      DONE:               state_outs = 6'b0000_10;
      default:            state_outs = 6'b1111_01;  // ERROR
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    retries_d = retries_q;
    case (state_q)
      IDLE, DONE, ERROR: if (start_i) begin
        state_d   = DISABLE;
        retries_d = '0;
      end
      DISABLE:    if (cnt_q == HoldLast)   state_d = IO_RESET;
      IO_RESET:   if (cnt_q == HoldLast)   state_d = CORE_RESET;
      CORE_RESET: if (cnt_q == SettleLast) state_d = ENABLE;
      ENABLE:                              state_d = WAIT_READY;
      WAIT_READY: begin
        // Ready seen in the timeout cycle still counts as success.
        if (&link_ready_i) state_d = DONE;
        else if (cnt_q == ToLast) begin
          if (retries_q < RetMax) begin
            retries_d = retries_q + RetW'(1);
            state_d   = DISABLE;
          end else begin
            state_d   = ERROR;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort_i) begin
      state_d   = IDLE;
      retries_d = '0;
    end

    // Counter restarts on every state change (including a retry back into
    // DISABLE) and saturates instead of wrapping.
    cnt_d = '0;
    if (state_d == state_q &&
        (state_q == DISABLE || state_q == IO_RESET ||
         state_q == CORE_RESET || state_q == WAIT_READY))
      cnt_d = (cnt_q == CntSat) ? cnt_q : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      retries_q <= '0;
      outs_q    <= state_outs(IDLE);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
      outs_q    <= state_outs(state_d);
    end
  end

  assign {link_disable_o, link_io_reset_o, link_core_reset_o,
          core_reset_o, done_o, error_o} = outs_q;
  assign retries_o = retries_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_bsg_sdr_link_bringup_sequencer.sv
module tb_bsg_sdr_link_bringup_sequencer;
  logic       clk = 1'b0;
  logic       reset_n, start, abort;
  logic [1:0] ready;
  logic       dis, ior, clr, crst, done, err;
  logic [1:0] retries;
  logic [2:0] state;
  int         n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  bsg_sdr_link_bringup_sequencer #(
    .num_links_p(2), .hold_cycles_p(4), .settle_cycles_p(8),
    .timeout_cycles_p(16), .max_retries_p(2)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .abort_i(abort),
    .link_ready_i(ready), .link_disable_o(dis), .link_io_reset_o(ior),
    .link_core_reset_o(clr), .core_reset_o(crst), .done_o(done),
    .error_o(err), .retries_o(retries), .state_o(state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One edge; sample 1 time unit after it.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [5:0] outs();
    return {dis, ior, clr, crst, done, err};
  endfunction

  // Expected state in cycle c of an attempt started at cycle 0 with ready held.
  function automatic logic [2:0] exp_state(input int c);
    if (c <= 4)  return 3'd1;
    if (c <= 8)  return 3'd2;
    if (c <= 16) return 3'd3;
    if (c == 17) return 3'd4;
    if (c == 18) return 3'd5;
    return 3'd6;
  endfunction

  // Start from a start-able state; cycle 1 is the first DISABLE cycle.
  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full good bring-up, optionally pulsing start during IO_RESET.
  task automatic run_good(input string tag, input bit pulse_io);
    ready = 2'b11;
    kick();
    for (int c = 1; c <= 19; c++) begin
      chk($sformatf("%s_st%0d", tag, c), 32'(state), 32'(exp_state(c)));
      start = pulse_io && (c == 5 || c == 7);
      if (c < 19) tick();
    end
    start = 1'b0;
    chk({tag, "_done_outs"}, 32'(outs()), 32'b0000_10);
    chk({tag, "_retries"}, 32'(retries), 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 2'b00;
    tick(2);
    chk("rst_state", 32'(state), 0);
    chk("rst_outs", 32'(outs()), 32'b1111_00);
    chk("rst_retries", 32'(retries), 0);
    reset_n = 1'b1;
    tick();
    chk("idle_hold", 32'(state), 0);

    // Nominal timeline, then again with stray start pulses in IO_RESET.
    run_good("good", 1'b0);
    tick(3);
    chk("done_hold", 32'(state), 6);
    ready = 2'b01;      // dropping ready in DONE is ignored
    tick();
    chk("done_drop", 32'(state), 6);
    run_good("iopulse", 1'b1);
    chk("io_outs_chk", 32'(outs()), 32'b0000_10);

    // Spot-check outputs of each timed phase.
    ready = 2'b01;
    kick();
    chk("dis_outs", 32'(outs()), 32'b1111_00);
    tick(4);
    chk("io_outs", 32'(outs()), 32'b0111_00);
    tick(4);
    chk("core_outs", 32'(outs()), 32'b0011_00);
    tick(8);
    chk("en_outs", 32'(outs()), 32'b0000_00);
    chk("en_state", 32'(state), 4);
    // Now at cycle 17; continue the timeout/retry scenario.
    tick(16);
    chk("to1_last_wait", 32'(state), 5);   // cycle 33 = 16th WAIT_READY cycle
    chk("to1_retries0", 32'(retries), 0);
    tick();
    chk("to1_state", 32'(state), 1);       // cycle 34
    chk("to1_retries", 32'(retries), 1);
    tick(33);
    chk("to2_state", 32'(state), 1);       // cycle 67
    chk("to2_retries", 32'(retries), 2);
    tick(32);
    chk("to3_last_wait", 32'(state), 5);   // cycle 99
    tick();
    chk("err_state", 32'(state), 7);       // cycle 100
    chk("err_outs", 32'(outs()), 32'b1111_01);
    tick(5);
    chk("err_sticky", 32'(state), 7);
    kick();
    chk("err_restart_st", 32'(state), 1);
    chk("err_restart_ret", 32'(retries), 0);
    chk("err_restart_err", 32'(err), 0);

    // Ready arrives exactly in the timeout cycle: DONE wins.
    ready = 2'b00;
    tick(32);                              // cycle 33
    chk("late_wait", 32'(state), 5);
    ready = 2'b11;
    tick();
    chk("late_done", 32'(state), 6);
    chk("late_retries", 32'(retries), 0);

    // Abort together with start during CORE_RESET.
    kick();
    tick(9);                               // cycle 10
    chk("ab_pre", 32'(state), 3);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("ab_state", 32'(state), 0);
    chk("ab_outs", 32'(outs()), 32'b1111_00);
    tick();
    chk("ab_stay", 32'(state), 0);

    // Synchronous reset pulse in WAIT_READY of a retry attempt.
    ready = 2'b00;
    kick();
    tick(54);                              // cycle 55
    chk("rs_pre_st", 32'(state), 5);
    chk("rs_pre_ret", 32'(retries), 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rs_state", 32'(state), 0);
    chk("rs_outs", 32'(outs()), 32'b1111_00);
    chk("rs_retries", 32'(retries), 0);
    tick();
    chk("rs_idle", 32'(state), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
